match_controller: RTL and testbench

Game-flow sequencer for Pong. Sits between the ball/collision stage and the score display: consumes one-cycle "point scored" pulses from the ball logic, owns both players' scores, and drives ball enable/re-serve plus the winner/flash indication that the score-font stage renders. All timing is counted in video frames, so pauses and blinking are resolution-independent.

---
 rtl/pong_pkg.sv | 20 ++
 rtl/frame_timer.sv | 30 +++
 rtl/match_controller.sv | 136 +++++++++++++
 tb/tb_match_controller.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// Shared Pong game-flow definitions: FSM state codes, score width, winner codes,
// and the saturating score increment.
package pong_pkg;

  localparam int SCORE_W = 4;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_PLAY  = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;
  localparam logic [1:0] ST_OVER  = 2'd3;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;

  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s);
    return (s == '1) ? s : s + SCORE_W'(1);
  endfunction

endpackage

// File: rtl/frame_timer.sv
// 8-bit frame-tick counter. Counts enabled ticks and pulses o_done on the tick
// that reaches i_target, restarting from zero so it can also pace a blink.
module frame_timer (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_clear,
  input  logic       i_enable,
  input  logic       i_tick,
  input  logic [7:0] i_target,
  output logic       o_done
);

  logic [7:0] count;
  logic [7:0] count_inc;

  assign count_inc = count + 8'd1;
  // Independent of i_clear: the owner derives its clear from this done.
  assign o_done    = i_enable & i_tick & (count_inc == i_target);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      count <= 8'd0;
    end else if (i_clear) begin
      count <= 8'd0;
    end else if (i_enable && i_tick) begin
      count <= o_done ? 8'd0 : count_inc;
    end
  end

endmodule

// File: rtl/match_controller.sv
// Pong match sequencer: owns both scores, serves the ball, pauses between points,
// and blinks the winner's score once a match is decided.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | ball held, waiting for a serve button edge
//   ST_PLAY  | ball moving, point pulses update the score
//   ST_PAUSE | ball held for SERVE_FRAMES frame ticks, then re-served
//   ST_OVER  | match won, winner digit blinks until the next serve edge
module match_controller
  import pong_pkg::*;
#(
  parameter int WIN_SCORE    = 9,
  parameter int SERVE_FRAMES = 60,
  parameter int FLASH_FRAMES = 30
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_frame_tick,
  input  logic               i_point1,
  input  logic               i_point2,
  input  logic               i_serve,
  output logic [SCORE_W-1:0] o_score1,
  output logic [SCORE_W-1:0] o_score2,
  output logic               o_ball_enable,
  output logic               o_ball_reset,
  output logic               o_serve_dir,
  output logic [1:0]         o_winner,
  output logic               o_flash
);

  localparam logic [SCORE_W-1:0] WIN_T   = SCORE_W'(WIN_SCORE);
  localparam logic [7:0]         SERVE_T = 8'(SERVE_FRAMES);
  localparam logic [7:0]         FLASH_T = 8'(FLASH_FRAMES);

  logic [1:0]         state;
  logic [1:0]         state_nx;
  logic               serve_q;
  logic               serve_rise;
  logic               only_p1;
  logic               only_p2;
  logic [SCORE_W-1:0] score1_inc;
  logic [SCORE_W-1:0] score2_inc;
  logic               timer_clear;
  logic               timer_en;
  logic               timer_done;
  logic [7:0]         timer_target;
  logic               entering;

  assign serve_rise = i_serve & ~serve_q;
  assign only_p1    = i_point1 & ~i_point2;
  assign only_p2    = i_point2 & ~i_point1;
  assign score1_inc = sat_inc(o_score1);
  assign score2_inc = sat_inc(o_score2);

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (serve_rise) state_nx = ST_PLAY;
      ST_PLAY: begin
        if (only_p1)      state_nx = (score1_inc == WIN_T) ? ST_OVER : ST_PAUSE;
        else if (only_p2) state_nx = (score2_inc == WIN_T) ? ST_OVER : ST_PAUSE;
        else if (i_point1 && i_point2) state_nx = ST_PAUSE;
      end
      ST_PAUSE: if (timer_done) state_nx = ST_PLAY;
      ST_OVER:  if (serve_rise) state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  assign timer_en     = (state == ST_PAUSE) || (state == ST_OVER);
  assign timer_target = (state == ST_OVER) ? FLASH_T : SERVE_T;
  assign timer_clear  = (state_nx != state);
  assign entering     = (state_nx != state) && (state_nx != ST_IDLE);

  frame_timer u_frame_timer (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_clear  (timer_clear),
    .i_enable (timer_en),
    .i_tick   (i_frame_tick),
    .i_target (timer_target),
    .o_done   (timer_done)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state         <= ST_IDLE;
      serve_q       <= 1'b0;
      o_score1      <= '0;
      o_score2      <= '0;
      o_ball_enable <= 1'b0;
      o_ball_reset  <= 1'b0;
      o_serve_dir   <= 1'b0;
      o_winner      <= WIN_NONE;
      o_flash       <= 1'b0;
    end else begin
      state         <= state_nx;
      serve_q       <= i_serve;
      o_ball_enable <= (state_nx == ST_PLAY);
      // A back-to-back transition reuses the recenter already in flight.
      o_ball_reset  <= entering && !o_ball_reset;
      case (state)
        ST_PLAY: begin
          if (only_p1) begin
            o_score1    <= score1_inc;
            o_serve_dir <= 1'b1;
            if (score1_inc == WIN_T) begin
              o_winner <= WIN_P1;
              o_flash  <= 1'b1;
            end
          end else if (only_p2) begin
            o_score2    <= score2_inc;
            o_serve_dir <= 1'b0;
            if (score2_inc == WIN_T) begin
              o_winner <= WIN_P2;
              o_flash  <= 1'b1;
            end
          end
        end
        ST_OVER: begin
          if (serve_rise) begin
            o_score1 <= '0;
            o_score2 <= '0;
            o_winner <= WIN_NONE;
            o_flash  <= 1'b0;
          end else if (timer_done) begin
            o_flash <= ~o_flash;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_match_controller.sv
// Directed bench for match_controller with default parameters (9 / 60 / 30).
module tb_match_controller;
  import pong_pkg::*;

  logic       i_clk = 1'b0;
  logic       i_reset = 1'b1;
  logic       i_frame_tick = 1'b0;
  logic       i_point1 = 1'b0;
  logic       i_point2 = 1'b0;
  logic       i_serve = 1'b0;
  logic [3:0] o_score1;
  logic [3:0] o_score2;
  logic       o_ball_enable;
  logic       o_ball_reset;
  logic       o_serve_dir;
  logic [1:0] o_winner;
  logic       o_flash;

  int vectors = 0;
  int miscompares = 0;
  int pulse_cnt = 0;
  int double_cnt = 0;
  logic prev_reset_pulse = 1'b0;

  match_controller dut (
    .i_clk         (i_clk),
    .i_reset       (i_reset),
    .i_frame_tick  (i_frame_tick),
    .i_point1      (i_point1),
    .i_point2      (i_point2),
    .i_serve       (i_serve),
    .o_score1      (o_score1),
    .o_score2      (o_score2),
    .o_ball_enable (o_ball_enable),
    .o_ball_reset  (o_ball_reset),
    .o_serve_dir   (o_serve_dir),
    .o_winner      (o_winner),
    .o_flash       (o_flash)
  );

  always #5 i_clk = ~i_clk;

  always @(negedge i_clk) begin
    if (o_ball_reset) pulse_cnt++;
    if (o_ball_reset && prev_reset_pulse) double_cnt++;
    prev_reset_pulse = o_ball_reset;
  end

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    i_frame_tick = 1'b1;
    step();
    i_frame_tick = 1'b0;
    repeat (3) step();
  endtask

  task automatic pause_out();
    repeat (60) tick();
  endtask

  initial begin
    repeat (3) step();
    check("rst_score1", 8'(o_score1), 8'd0);
    check("rst_score2", 8'(o_score2), 8'd0);
    check("rst_enable", 8'(o_ball_enable), 8'd0);
    check("rst_ball_reset", 8'(o_ball_reset), 8'd0);
    check("rst_serve_dir", 8'(o_serve_dir), 8'd0);
    check("rst_winner", 8'(o_winner), 8'd0);
    check("rst_flash", 8'(o_flash), 8'd0);
    check("rst_state", 8'(dut.state), 8'(ST_IDLE));

    i_reset = 1'b0;
    step();
    i_point1 = 1'b1;
    step();
    i_point1 = 1'b0;
    check("idle_point_score1", 8'(o_score1), 8'd0);
    check("idle_point_state", 8'(dut.state), 8'(ST_IDLE));

    // Serve edge, then hold the button
    pulse_cnt = 0;
    i_serve = 1'b1;
    step();
    check("serve_state", 8'(dut.state), 8'(ST_PLAY));
    check("serve_enable", 8'(o_ball_enable), 8'd1);
    check("serve_ball_reset", 8'(o_ball_reset), 8'd1);
    repeat (100) step();
    check("serve_hold_pulses", 8'(pulse_cnt), 8'd1);
    check("serve_hold_state", 8'(dut.state), 8'(ST_PLAY));
    i_serve = 1'b0;
    step();

    // Player 2 scores
    i_point2 = 1'b1;
    step();
    i_point2 = 1'b0;
    check("p2_score2", 8'(o_score2), 8'd1);
    check("p2_score1", 8'(o_score1), 8'd0);
    check("p2_serve_dir", 8'(o_serve_dir), 8'd0);
    check("p2_enable", 8'(o_ball_enable), 8'd0);
    check("p2_ball_reset", 8'(o_ball_reset), 8'd1);
    check("p2_state", 8'(dut.state), 8'(ST_PAUSE));
    step();
    check("p2_ball_reset_drop", 8'(o_ball_reset), 8'd0);
    pulse_cnt = 0;
    i_serve = 1'b1;
    repeat (59) tick();
    i_serve = 1'b0;
    check("pause59_enable", 8'(o_ball_enable), 8'd0);
    check("pause59_state", 8'(dut.state), 8'(ST_PAUSE));
    i_frame_tick = 1'b1;
    step();
    i_frame_tick = 1'b0;
    check("pause60_enable", 8'(o_ball_enable), 8'd1);
    check("pause60_ball_reset", 8'(o_ball_reset), 8'd1);
    check("pause60_state", 8'(dut.state), 8'(ST_PLAY));
    step();
    check("pause60_pulses", 8'(pulse_cnt), 8'd1);

    // Player 1 scores, then a simultaneous point
    i_point1 = 1'b1;
    step();
    i_point1 = 1'b0;
    check("p1_score1", 8'(o_score1), 8'd1);
    check("p1_serve_dir", 8'(o_serve_dir), 8'd1);
    pause_out();
    check("p1_back_in_play", 8'(dut.state), 8'(ST_PLAY));
    i_point1 = 1'b1;
    i_point2 = 1'b1;
    step();
    i_point1 = 1'b0;
    i_point2 = 1'b0;
    check("both_score1", 8'(o_score1), 8'd1);
    check("both_score2", 8'(o_score2), 8'd1);
    check("both_serve_dir", 8'(o_serve_dir), 8'd1);
    check("both_state", 8'(dut.state), 8'(ST_PAUSE));
    check("both_enable", 8'(o_ball_enable), 8'd0);
    step();
    i_point1 = 1'b1;
    step();
    i_point1 = 1'b0;
    check("pause_point_score1", 8'(o_score1), 8'd1);
    pause_out();

    // Player 1 runs to WIN_SCORE
    for (int i = 0; i < 8; i++) begin
      i_point1 = 1'b1;
      step();
      i_point1 = 1'b0;
      check("run_score1", 8'(o_score1), 8'(2 + i));
      if (i < 7) begin
        check("run_state", 8'(dut.state), 8'(ST_PAUSE));
        pause_out();
      end
    end
    check("win_winner", 8'(o_winner), 8'(WIN_P1));
    check("win_state", 8'(dut.state), 8'(ST_OVER));
    check("win_flash", 8'(o_flash), 8'd1);
    check("win_enable", 8'(o_ball_enable), 8'd0);
    check("win_ball_reset", 8'(o_ball_reset), 8'd1);
    i_point2 = 1'b1;
    step();
    i_point2 = 1'b0;
    check("over_point_score2", 8'(o_score2), 8'd1);

    repeat (29) tick();
    check("flash_t29", 8'(o_flash), 8'd1);
    tick();
    check("flash_t30", 8'(o_flash), 8'd0);
    repeat (29) tick();
    check("flash_t59", 8'(o_flash), 8'd0);
    tick();
    check("flash_t60", 8'(o_flash), 8'd1);

    i_serve = 1'b1;
    step();
    check("restart_score1", 8'(o_score1), 8'd0);
    check("restart_score2", 8'(o_score2), 8'd0);
    check("restart_winner", 8'(o_winner), 8'd0);
    check("restart_flash", 8'(o_flash), 8'd0);
    check("restart_state", 8'(dut.state), 8'(ST_IDLE));
    i_serve = 1'b0;
    step();

    // Reset in the middle of a pause
    i_serve = 1'b1;
    step();
    i_serve = 1'b0;
    check("r_serve_state", 8'(dut.state), 8'(ST_PLAY));
    i_point2 = 1'b1;
    step();
    i_point2 = 1'b0;
    check("r_p2_score2", 8'(o_score2), 8'd1);
    repeat (29) tick();
    i_frame_tick = 1'b1;
    i_reset = 1'b1;
    step();
    i_frame_tick = 1'b0;
    i_reset = 1'b0;
    check("mid_rst_state", 8'(dut.state), 8'(ST_IDLE));
    check("mid_rst_score2", 8'(o_score2), 8'd0);
    check("mid_rst_enable", 8'(o_ball_enable), 8'd0);
    check("mid_rst_ball_reset", 8'(o_ball_reset), 8'd0);
    check("mid_rst_serve_dir", 8'(o_serve_dir), 8'd0);
    tick();
    check("post_rst_tick_state", 8'(dut.state), 8'(ST_IDLE));
    check("post_rst_tick_enable", 8'(o_ball_enable), 8'd0);

    check("no_double_pulse", 8'(double_cnt), 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
